// File: rtl/dsp_chain_pkg.sv
// Shared mode encodings and default widths for the sum-of-products lane array.
// Imported by the lane datapath and the array top.
package dsp_chain_pkg;

    typedef enum logic [1:0] {
        MODE_SOP  = 2'b00,
        MODE_DIFF = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int DEF_NUM_LANES = 8;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ACC_W     = 32;

endpackage

// File: rtl/dsp_chain_sop2_lane.sv
// One lane: operand regs, two signed products, saturated SOP/DIFF/ACC result and accumulator.
// Latency 3 (S1 operands, S2 products, S3 result); every stage holds while adv is low.
// Backpressure comes from the top through adv; the accumulator only moves when S3 loads.
module dsp_chain_sop2_lane
    import dsp_chain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adv,
    input  logic                v2,
    input  logic [1:0]          mode2,
    input  logic                clr2,
    input  logic [4*DATA_W-1:0] opnd,
    output logic [ACC_W-1:0]    res,
    output logic                ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] MAXV = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic signed [DATA_W-1:0] a1, b1, c1, d1;
    logic signed [PW-1:0]     p0, p1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PW:0]       sum2;
    logic signed [SW-1:0]     base, wide;
    logic [ACC_W-1:0]         nxt;
    logic                     nxt_ovf;

    // SW bits hold base+p0+p1 without wrap because ACC_W >= 2*DATA_W.
    always_comb begin
        sum2    = '0;
        base    = '0;
        wide    = '0;
        nxt     = '0;
        nxt_ovf = 1'b0;
        if (mode2 == MODE_DIFF) sum2 = {p0[PW-1], p0} - {p1[PW-1], p1};
        else                    sum2 = {p0[PW-1], p0} + {p1[PW-1], p1};
        base = clr2 ? '0 : SW'(acc);
        if (mode2 == MODE_ACC) wide = base + SW'(p0) + SW'(p1);
        else                   wide = SW'(sum2);
        if (wide > MAXV) begin
            nxt     = MAXV[ACC_W-1:0];
            nxt_ovf = 1'b1;
        end else if (wide < MINV) begin
            nxt     = MINV[ACC_W-1:0];
            nxt_ovf = 1'b1;
        end else begin
            nxt = wide[ACC_W-1:0];
        end
        if (mode2 == MODE_RSVD) begin
            nxt     = '0;
            nxt_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1  <= '0;
            b1  <= '0;
            c1  <= '0;
            d1  <= '0;
            p0  <= '0;
            p1  <= '0;
            res <= '0;
            ovf <= 1'b0;
            acc <= '0;
        end else if (adv) begin
            a1 <= opnd[0*DATA_W +: DATA_W];
            b1 <= opnd[1*DATA_W +: DATA_W];
            c1 <= opnd[2*DATA_W +: DATA_W];
            d1 <= opnd[3*DATA_W +: DATA_W];
            p0 <= a1 * b1;
            p1 <= c1 * d1;
            if (v2) begin
                res <= nxt;
                ovf <= nxt_ovf;
                if (mode2 == MODE_ACC) acc <= nxt;
            end
        end
    end

endmodule

// File: rtl/dsp_chain_sop2_acc_array.sv
// Array of NUM_LANES sum-of-products lanes sharing one valid pipeline and stall.
// Latency 3 cycles from acceptance to out_valid; one result per cycle when unstalled.
// A held result (out_valid & !out_ready) freezes every stage; in_ready drops meanwhile.
module dsp_chain_sop2_acc_array
    import dsp_chain_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    mode,
    input  logic                          acc_clear,
    input  logic [NUM_LANES*4*DATA_W-1:0] inp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*ACC_W-1:0]    outp,
    output logic [NUM_LANES-1:0]          overflow
);

    logic       v1, v2, v3;
    logic [1:0] mode1, mode2;
    logic       clr1, clr2;
    logic       adv;

    assign adv       = !v3 || out_ready;
    assign in_ready  = reset && adv;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            mode1 <= MODE_SOP;
            mode2 <= MODE_SOP;
            clr1  <= 1'b0;
            clr2  <= 1'b0;
        end else if (adv) begin
            v1    <= in_valid;
            v2    <= v1;
            v3    <= v2;
            mode1 <= mode;
            clr1  <= acc_clear;
            mode2 <= mode1;
            clr2  <= clr1;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dsp_chain_sop2_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .adv   (adv),
            .v2    (v2),
            .mode2 (mode2),
            .clr2  (clr2),
            .opnd  (inp[g*4*DATA_W +: 4*DATA_W]),
            .res   (outp[g*ACC_W +: ACC_W]),
            .ovf   (overflow[g])
        );
    end

endmodule

// File: tb/tb_dsp_chain_sop2_acc_array.sv
// Scoreboard bench for dsp_chain_sop2_acc_array at default widths.
module tb_dsp_chain_sop2_acc_array;

    localparam int NL = 8;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int IW = NL * 4 * DW;
    localparam int OW = NL * AW;

    typedef struct packed {
        logic [OW-1:0] o;
        logic [NL-1:0] ov;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic          acc_clear;
    logic [IW-1:0] inp;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] outp;
    logic [NL-1:0] overflow;

    int checks   = 0;
    int failures = 0;

    exp_t          sb[$];
    logic [AW-1:0] obs_q[$];
    longint        macc[NL];
    logic [OW-1:0] last_out;
    logic [NL-1:0] last_ovf;

    dsp_chain_sop2_acc_array dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_clear (acc_clear),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] m, input logic clr, input logic [IW-1:0] d);
        exp_t   e;
        longint a, b, c, dd, s, r;
        longint maxv = (longint'(1) <<< (AW - 1)) - 1;
        longint minv = -(longint'(1) <<< (AW - 1));
        e = '0;
        for (int l = 0; l < NL; l++) begin
            a  = longint'($signed(d[l*4*DW + 0*DW +: DW]));
            b  = longint'($signed(d[l*4*DW + 1*DW +: DW]));
            c  = longint'($signed(d[l*4*DW + 2*DW +: DW]));
            dd = longint'($signed(d[l*4*DW + 3*DW +: DW]));
            case (m)
                2'b00:   s = a * b + c * dd;
                2'b01:   s = a * b - c * dd;
                2'b10:   s = (clr ? 64'sd0 : macc[l]) + a * b + c * dd;
                default: s = 0;
            endcase
            r = s;
            if (s > maxv) begin r = maxv; e.ov[l] = 1'b1; end
            if (s < minv) begin r = minv; e.ov[l] = 1'b1; end
            if (m == 2'b10) macc[l] = r;
            e.o[l*AW +: AW] = r[AW-1:0];
        end
        return e;
    endfunction

    function automatic logic [IW-1:0] pack_all(input int a, input int b, input int c, input int d);
        logic [IW-1:0] v;
        v = '0;
        for (int l = 0; l < NL; l++) begin
            v[l*4*DW + 0*DW +: DW] = DW'(a);
            v[l*4*DW + 1*DW +: DW] = DW'(b);
            v[l*4*DW + 2*DW +: DW] = DW'(c);
            v[l*4*DW + 3*DW +: DW] = DW'(d);
        end
        return v;
    endfunction

    // Scoreboard: every handshaken result is popped and compared in order.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got outp=%h ovf=%b with no expected entry", outp, overflow);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (outp !== e.o || overflow !== e.ov) begin
                    failures++;
                    $display("FAIL sb_result got outp=%h ovf=%b exp outp=%h ovf=%b", outp, overflow, e.o, e.ov);
                end
            end
            last_out = outp;
            last_ovf = overflow;
            obs_q.push_back(outp[AW-1:0]);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [1:0] m, input logic clr, input logic [IW-1:0] data);
        logic acc;
        int   n;
        sb.push_back(model(m, clr, data));
        in_valid  = 1'b1;
        mode      = m;
        acc_clear = clr;
        inp       = data;
        n         = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%b after %0d cycles, required 1", in_ready, n);
            void'(sb.pop_back());
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        mode      = 2'b00;
        acc_clear = 1'b0;
        inp       = pack_all(1, 1, 1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
        if (outp !== '0) begin failures++; $display("FAIL rst_outp got %h required 0", outp); end
        if (overflow !== '0) begin failures++; $display("FAIL rst_overflow got %b required 0", overflow); end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got %b required 1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_release_out_valid got %b required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sop_latency();
        logic [IW-1:0] d;
        int            n;
        d = '0;
        d[0*DW +: DW] = 16'sd3;
        d[1*DW +: DW] = 16'sd4;
        d[2*DW +: DW] = -16'sd2;
        d[3*DW +: DW] = 16'sd5;
        out_ready = 1'b1;
        send(2'b00, 1'b0, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        checks += 3;
        if (n != 3) begin failures++; $display("FAIL sop_latency got %0d cycles required 3", n); end
        if (outp[AW-1:0] !== 32'd2) begin failures++; $display("FAIL sop_lane0 got %0d required 2", $signed(outp[AW-1:0])); end
        if (overflow[0] !== 1'b0) begin failures++; $display("FAIL sop_ovf got %b required 0", overflow[0]); end
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        send(2'b00, 1'b0, pack_all(-32768, -32768, -32768, -32768));
        drain();
        checks += 2;
        if (last_out[AW-1:0] !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_sop got %h required 7fffffff", last_out[AW-1:0]); end
        if (last_ovf !== {NL{1'b1}}) begin failures++; $display("FAIL sat_sop_ovf got %b required all ones", last_ovf); end
        send(2'b01, 1'b0, pack_all(-32768, -32768, -32768, -32768));
        send(2'b11, 1'b1, pack_all(-32768, -32768, -32768, -32768));
        drain();
        checks++;
        if (last_out !== '0 || last_ovf !== '0) begin failures++; $display("FAIL rsvd_zero got %h ovf=%b required 0", last_out, last_ovf); end
    endtask

    task automatic test_acc();
        out_ready = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 4; i++) send(2'b10, (i == 0), pack_all(10, 10, 0, 0));
        drain();
        checks++;
        if (obs_q.size() != 4) begin
            failures++;
            $display("FAIL acc_count got %0d required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i] !== AW'(100 * (i + 1))) begin
                    failures++;
                    $display("FAIL acc_seq idx=%0d got %0d required %0d", i, obs_q[i], 100 * (i + 1));
                end
            end
        end
        send(2'b00, 1'b1, pack_all(7, 9, 3, 3));
        send(2'b10, 1'b0, pack_all(0, 0, 0, 0));
        drain();
        checks++;
        if (last_out[AW-1:0] !== 32'd400) begin failures++; $display("FAIL acc_hold got %0d required 400", last_out[AW-1:0]); end
    endtask

    task automatic test_stall();
        logic [OW-1:0] snap;
        int            n;
        logic [3:0]    pat;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'b00, 1'b0, pack_all(i + 1, 100, i, -7));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        snap = outp;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got %b required 1", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got %b required 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (outp !== snap || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got %h valid=%b required %h valid=1", i, outp, out_valid, snap);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = out_valid;
        end
        checks++;
        if (pat !== 4'b0111) begin failures++; $display("FAIL stall_release pattern got %b required 0111", pat); end
        drain();
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b1;
        send(2'b10, 1'b1, pack_all(100, 100, 0, 0));
        send(2'b10, 1'b1, pack_all(200, 200, 0, 0));
        reset = 1'b0;
        sb.delete();
        for (int l = 0; l < NL; l++) macc[l] = 0;
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got %b required 0", out_valid); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks += 2;
        if (stale != 0) begin failures++; $display("FAIL mid_rst_stale got %0d valid cycles required 0", stale); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %b required 1", in_ready); end
        @(posedge clk);
        #1;
        send(2'b10, 1'b0, pack_all(1, 1, 0, 0));
        drain();
        checks++;
        if (last_out !== {NL{32'd1}}) begin failures++; $display("FAIL mid_rst_acc got %h required all lanes 1", last_out); end
    endtask

    task automatic test_lanes();
        logic [IW-1:0] d;
        d = '0;
        for (int l = 0; l < NL; l++) begin
            d[l*4*DW + 0*DW +: DW] = DW'(l + 1);
            d[l*4*DW + 1*DW +: DW] = DW'(2);
            d[l*4*DW + 2*DW +: DW] = DW'(l);
            d[l*4*DW + 3*DW +: DW] = DW'(-1);
        end
        out_ready = 1'b1;
        send(2'b00, 1'b0, d);
        drain();
        for (int l = 0; l < NL; l++) begin
            checks++;
            if (last_out[l*AW +: AW] !== AW'(l + 2)) begin
                failures++;
                $display("FAIL lane_slice lane=%0d got %0d required %0d", l, last_out[l*AW +: AW], l + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  run;
        int  n;
        bit  done;
        logic [IW-1:0] d;
        out_ready = 1'b1;
        run = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int w = 0; w < IW / 32; w++) d[w*32 +: 32] = $urandom;
                    send(2'($urandom_range(0, 1)), 1'b0, d);
                end
            end
            begin
                n = 0;
                while (!out_valid && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                while (out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (run != 10) begin failures++; $display("FAIL b2b_throughput got run of %0d required 10", run); end
        drain();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    for (int w = 0; w < IW / 32; w++) d[w*32 +: 32] = $urandom;
                    if ($urandom_range(0, 3) == 0) d[15:0] = 16'h8000;
                    send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int l = 0; l < NL; l++) macc[l] = 0;
        last_out = '0;
        last_ovf = '0;
        test_reset();
        test_sop_latency();
        test_saturation();
        test_acc();
        test_stall();
        test_reset_midflight();
        test_lanes();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_chain_sop2_acc_array.md
DSP_CHAIN_SOP2_ACC_ARRAY -- requirements
Module: dsp_chain_sop2_acc_array

Interface
REQ-001 Parameter NUM_LANES, default 8: number of independent sum-of-products lanes; legal range 1..16.
REQ-002 Parameter DATA_W, default 16: signed operand width; legal range 8..18.
REQ-003 Parameter ACC_W, default 32: signed result/accumulator width; legal range 2*DATA_W..48.
REQ-004 clk  input  1  single clock; all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 in_valid  input  1  input transaction present.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 mode  input  2  00 SOP, 01 DIFF, 10 ACC, 11 reserved; sampled with the transaction.
REQ-009 acc_clear  input  1  in ACC mode, start from zero instead of the stored accumulator; sampled with the transaction.
REQ-010 inp  input  NUM_LANES*4*DATA_W  lane i occupies the slice at base i*4*DATA_W; operands a,b,c,d from LSB upward, DATA_W bits each.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 outp  output  NUM_LANES*ACC_W  lane i result at [i*ACC_W +: ACC_W].
REQ-014 overflow  output  NUM_LANES  per-lane saturation flag, qualified by out_valid.

Function
REQ-015 A transaction SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL equal (not out_valid) or out_ready.
REQ-017 Pipeline: S1 registers operands, mode and acc_clear; S2 registers signed products p0=a*b and p1=c*d (2*DATA_W bits each); S3 registers the result. With no stall, latency SHALL be exactly 3 cycles from acceptance to out_valid.
REQ-018 When out_valid=1 and out_ready=0, all stages SHALL hold (global stall); outp, overflow and all lane state SHALL remain stable.
REQ-019 A bubble (valid=0) stage SHALL advance without stall so that bubbles collapse; back-to-back acceptance every cycle SHALL sustain one result per cycle.
REQ-020 SOP: result = sat(p0+p1). DIFF: result = sat(p0-p1). The sum SHALL be computed at 2*DATA_W+1 bits before saturation.
REQ-021 ACC: new = sat(base+p0+p1), where base = 0 if acc_clear else the lane accumulator. Result = new. The accumulator SHALL be updated to new only when the S3 stage advances.
REQ-022 SOP and DIFF SHALL NOT modify the accumulator; acc_clear SHALL be ignored outside ACC mode.
REQ-023 Reserved mode SHALL produce result 0 and overflow 0, and SHALL leave the accumulator unchanged.
REQ-024 sat() SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. The lane overflow bit SHALL be 1 exactly when clamping occurred for that transaction; the bit is not sticky.
REQ-025 Consecutive ACC transactions in adjacent cycles SHALL see the accumulator value written by their predecessor, with no hazard.
REQ-026 out_valid SHALL deassert on the edge where out_valid and out_ready are both 1, unless a new result advances into S3 on the same edge.

Reset
REQ-027 While reset=0: out_valid=0, all stage valids=0, outp=0, overflow=0, all accumulators=0, and in_ready=0.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; after release in_ready=1 and no stale result appears.

Structure
REQ-029 Package dsp_chain_pkg SHALL hold the mode encodings (MODE_SOP, MODE_DIFF, MODE_ACC, MODE_RSVD) and the default width constants.
REQ-030 A sub-module dsp_chain_sop2_lane SHALL implement one lane's datapath and accumulator; the top SHALL instantiate NUM_LANES lanes via generate and own the shared valid/stall control.

Verification
REQ-031 SOP, lane 0 a=3, b=4, c=-2, d=5, out_ready=1 -> outp lane0=2, overflow=0, out_valid exactly 3 cycles after acceptance.
REQ-032 SOP, a=b=c=d=-32768 (defaults) -> lane result 0x7FFFFFFF, overflow=1; DIFF with the same operands -> 0, overflow=0.
REQ-033 ACC, four back-to-back transactions a=b=10, c=d=0, first with acc_clear=1 -> results 100, 200, 300, 400; a following SOP leaves the accumulator at 400.
REQ-034 Accept 3 transactions, hold out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1, outp stable; release -> 3 results in order on consecutive cycles, none lost or duplicated.
REQ-035 Assert reset for 1 cycle with 2 transactions in flight -> no out_valid afterwards, accumulators read 0 (ACC with acc_clear=0, a=b=1, c=d=0 -> result 1).
REQ-036 NUM_LANES=8, distinct operands per lane -> each lane result lands in its own slice; no cross-lane bleed.
